// File: rtl/exec_ctrl_pkg.sv
// exec_ctrl_pkg
//   Shared definitions for the tiny processor's fetch/decode/execute sequencer.
//   Contents:
//     unit_e  - ALU unit codes carried in ir[7:5]; the ALU decode uses the same values
//     state_e - sequencer FSM states
//     dec_e   - instruction class as seen by the sequencer (ALU op, BNEZ, ST, HALT)
//     decode_class() - classifies an instruction word into dec_e
//     is_ldi()       - true when the operand comes from the immediate field
package exec_ctrl_pkg;

  localparam int INSTR_W = 8;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    UNIT_ADD   = 3'd0,
    UNIT_LOGIC = 3'd1,
    UNIT_SHIFT = 3'd2,
    UNIT_LOAD  = 3'd3,
    UNIT_MUL   = 3'd4,
    UNIT_CMP   = 3'd5,
    UNIT_MISC  = 3'd6,
    UNIT_BR    = 3'd7
  } unit_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EXEC  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DEC_ALU  = 2'd0,
    DEC_BNEZ = 2'd1,
    DEC_ST   = 2'd2,
    DEC_HALT = 2'd3
  } dec_e;

  // Unit 111 is the only non-ALU unit; op and ir[3] split it into BNEZ/ST/HALT.
  function automatic dec_e decode_class(input logic [INSTR_W-1:0] ir);
    dec_e cls;
    if (ir[7:5] != UNIT_BR) begin
      cls = DEC_ALU;
    end else if (!ir[4]) begin
      cls = DEC_BNEZ;
    end else if (!ir[3]) begin
      cls = DEC_ST;
    end else begin
      cls = DEC_HALT;
    end
    return cls;
  endfunction

  function automatic logic is_ldi(input logic [INSTR_W-1:0] ir);
    return (ir[7:5] == UNIT_LOAD) && ir[4];
  endfunction

endpackage

// File: rtl/exec_ctrl_acc_regfile.sv
// acc_regfile
//   Accumulator plus an NREGS x 8 register file.
//   Ports:
//     i_clk, i_rst            clock, asynchronous active-high reset (clears acc and all regs)
//     i_acc_we, i_acc_wdata   accumulator write port
//     i_reg_we, i_reg_waddr,
//     i_reg_wdata             register file write port
//     i_rd_addr, o_rd_data    asynchronous register read port
//     o_acc                   current accumulator value
module acc_regfile
  import exec_ctrl_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_acc_we,
  input  logic [DATA_W-1:0] i_acc_wdata,
  input  logic              i_reg_we,
  input  logic [IDX_W-1:0]  i_reg_waddr,
  input  logic [DATA_W-1:0] i_reg_wdata,
  input  logic [IDX_W-1:0]  i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [DATA_W-1:0] o_acc
);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_regs [NREGS];

  // Accumulator: only written when the sequencer commits an ALU instruction.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_acc_we) begin
      r_acc <= i_acc_wdata;
    end
  end

  // Register file: reset clears every entry so the ALU source operand is defined from the start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_reg_we) begin
      r_regs[i_reg_waddr] <= i_reg_wdata;
    end
  end

  assign o_rd_data = r_regs[i_rd_addr];
  assign o_acc     = r_acc;

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl
//   Fetch/decode/execute sequencer sitting directly upstream of the ALU.
//   Each instruction takes exactly three cycles: FETCH (read strobe), WAIT (latch ir), EXEC (commit).
//   Ports:
//     clk_in, rst_in        clock, asynchronous active-high reset
//     start_in              run request from the host, honoured only in IDLE
//     busy_out, done_out    run in progress / one-cycle pulse when HALT retires
//     imem_rd_out,
//     imem_addr_out,
//     imem_data_in          program memory read (data one cycle after the strobe)
//     alu_unit_sel_out,
//     alu_op_sel_out,
//     alu_acc_out,
//     alu_src_out,
//     alu_res_in            ALU operand/select outputs and combinational result
//     acc_out, pc_out       observation of accumulator and program counter
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int PC_W  = 4,
  parameter int NREGS = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  output logic               busy_out,
  output logic               done_out,
  output logic               imem_rd_out,
  output logic [PC_W-1:0]    imem_addr_out,
  input  logic [INSTR_W-1:0] imem_data_in,
  output logic [2:0]         alu_unit_sel_out,
  output logic               alu_op_sel_out,
  output logic [DATA_W-1:0]  alu_acc_out,
  output logic [DATA_W-1:0]  alu_src_out,
  input  logic [DATA_W-1:0]  alu_res_in,
  output logic [DATA_W-1:0]  acc_out,
  output logic [PC_W-1:0]    pc_out
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     w_pc_nxt;
  logic [PC_W-1:0]     w_pc_inc;
  logic [PC_W-1:0]     w_br_target;
  logic [INSTR_W-1:0]  r_ir;
  logic [INSTR_W-1:0]  w_ir_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                w_acc_we;
  logic                w_reg_we;
  logic [DATA_W-1:0]   w_acc;
  logic [DATA_W-1:0]   w_src_reg;
  dec_e                w_dec;

  assign w_dec       = decode_class(r_ir);
  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_br_target = PC_W'(r_ir[3:0]);

  // State, pc, ir and the done pulse register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and commit control. Nothing architectural changes outside EXEC except
  // pc reload on an accepted start and ir capture in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_done_nxt  = 1'b0;
    w_acc_we    = 1'b0;
    w_reg_we    = 1'b0;
    imem_rd_out = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_in) begin
          w_pc_nxt    = '0;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_rd_out = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_ir_nxt    = imem_data_in;
        w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_nxt = ST_FETCH;
        w_pc_nxt    = w_pc_inc;
        case (w_dec)
          DEC_ALU: begin
            w_acc_we = 1'b1;
          end
          DEC_BNEZ: begin
            if (w_acc != '0) begin
              w_pc_nxt = w_br_target;
            end
          end
          DEC_ST: begin
            w_reg_we = 1'b1;
          end
          default: begin
            // HALT leaves pc pointing at itself and pulses done on entry to IDLE.
            w_pc_nxt    = r_pc;
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        endcase
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  acc_regfile #(
    .NREGS (NREGS),
    .IDX_W (IDX_W)
  ) u_acc_regfile (
    .i_clk       (clk_in),
    .i_rst       (rst_in),
    .i_acc_we    (w_acc_we),
    .i_acc_wdata (alu_res_in),
    .i_reg_we    (w_reg_we),
    .i_reg_waddr (r_ir[IDX_W-1:0]),
    .i_reg_wdata (w_acc),
    .i_rd_addr   (r_ir[IDX_W-1:0]),
    .o_rd_data   (w_src_reg),
    .o_acc       (w_acc)
  );

  // ALU operands are driven continuously from ir/acc/regs; only EXEC commits the result.
  assign alu_unit_sel_out = r_ir[7:5];
  assign alu_op_sel_out   = r_ir[4];
  assign alu_acc_out      = w_acc;
  assign alu_src_out      = is_ldi(r_ir) ? {4'b0000, r_ir[3:0]} : w_src_reg;

  assign busy_out      = (r_state != ST_IDLE);
  assign done_out      = r_done;
  assign imem_addr_out = r_pc;
  assign acc_out       = w_acc;
  assign pc_out        = r_pc;

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl
//   Directed bench for exec_ctrl with a program memory model, an attached ALU model,
//   and an instruction-level reference model that predicts the fetch address stream
//   into a scoreboard queue, popped on every observed read strobe.
module tb_exec_ctrl;

  localparam int PC_W  = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       startIn = 1'b0;
  logic       busyOut;
  logic       doneOut;
  logic       imemRd;
  logic [3:0] imemAddr;
  logic [7:0] imemData = 8'h00;
  logic [2:0] aluUnit;
  logic       aluOp;
  logic [7:0] aluAcc;
  logic [7:0] aluSrc;
  logic [7:0] aluRes;
  logic [7:0] accOut;
  logic [3:0] pcOut;

  logic [7:0] imem [DEPTH];
  logic [7:0] mAcc;
  logic [7:0] mRegs [8];
  logic [3:0] expPcQ [$];

  int checks     = 0;
  int failures   = 0;
  int cycleCnt   = 0;
  int doneCount  = 0;

  exec_ctrl #(.PC_W(PC_W), .NREGS(8)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .start_in         (startIn),
    .busy_out         (busyOut),
    .done_out         (doneOut),
    .imem_rd_out      (imemRd),
    .imem_addr_out    (imemAddr),
    .imem_data_in     (imemData),
    .alu_unit_sel_out (aluUnit),
    .alu_op_sel_out   (aluOp),
    .alu_acc_out      (aluAcc),
    .alu_src_out      (aluSrc),
    .alu_res_in       (aluRes),
    .acc_out          (accOut),
    .pc_out           (pcOut)
  );

  always #5 clk = ~clk;

  // Reference ALU, shared by the attached hardware model and the instruction model.
  function automatic logic [7:0] aluModel(input logic [2:0] unit, input logic op,
                                          input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    logic [7:0]  r;
    prod = 16'(a) * 16'(b);
    case (unit)
      3'd0:    r = op ? (a - b) : (a + b);
      3'd1:    r = op ? (a | b) : (a & b);
      3'd2:    r = op ? (a >> 1) : (a << 1);
      3'd3:    r = b;
      3'd4:    r = prod[7:0];
      3'd5:    r = op ? ~a : (a ^ b);
      3'd6:    r = op ? b : a;
      default: r = a;
    endcase
    return r;
  endfunction

  assign aluRes = aluModel(aluUnit, aluOp, aluAcc, aluSrc);

  // Program memory: data appears one cycle after the read strobe.
  always @(posedge clk) begin
    if (imemRd) imemData <= imem[imemAddr];
  end

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard pop on every fetch strobe; done pulses are counted for the no-extra-done checks.
  always @(negedge clk) begin
    if (doneOut) doneCount++;
    if (imemRd) begin
      if (expPcQ.size() == 0) begin
        checkOutput("fetch_unexpected", {28'd0, imemAddr}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("fetch_addr", {28'd0, imemAddr}, {28'd0, expPcQ.pop_front()});
      end
    end
  end

  // Instruction-level model: predicts fetch addresses and architectural state.
  task automatic issRun(input int maxInstr, output int nInstr);
    logic [3:0] pc;
    logic [7:0] ir;
    logic [7:0] src;
    bit halted;
    pc = 4'd0;
    nInstr = 0;
    halted = 1'b0;
    while (nInstr < maxInstr && !halted) begin
      ir = imem[pc];
      expPcQ.push_back(pc);
      nInstr++;
      if (ir[7:5] == 3'b111) begin
        if (!ir[4]) begin
          pc = (mAcc != 8'd0) ? ir[3:0] : pc + 4'd1;
        end else if (!ir[3]) begin
          mRegs[ir[2:0]] = mAcc;
          pc = pc + 4'd1;
        end else begin
          halted = 1'b1;
        end
      end else begin
        src  = (ir[7:4] == 4'b0111) ? {4'd0, ir[3:0]} : mRegs[ir[2:0]];
        mAcc = aluModel(ir[7:5], ir[4], mAcc, src);
        pc   = pc + 4'd1;
      end
    end
  endtask

  task automatic fillHalt();
    for (int i = 0; i < DEPTH; i++) imem[i] = 8'hF8;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},  {31'd0, busyOut}, 32'd0);
    checkOutput({tag, "_done"},  {31'd0, doneOut}, 32'd0);
    checkOutput({tag, "_rd"},    {31'd0, imemRd},  32'd0);
    checkOutput({tag, "_addr"},  {28'd0, imemAddr}, 32'd0);
    checkOutput({tag, "_unit"},  {29'd0, aluUnit}, 32'd0);
    checkOutput({tag, "_op"},    {31'd0, aluOp},   32'd0);
    checkOutput({tag, "_aluacc"},{24'd0, aluAcc},  32'd0);
    checkOutput({tag, "_src"},   {24'd0, aluSrc},  32'd0);
    checkOutput({tag, "_acc"},   {24'd0, accOut},  32'd0);
    checkOutput({tag, "_pc"},    {28'd0, pcOut},   32'd0);
  endtask

  // Asserts reset immediately (asynchronously), checks outputs, releases on the next negedge.
  task automatic applyReset(input string tag);
    rst = 1'b1;
    startIn = 1'b0;
    #1;
    checkResetOutputs(tag);
    @(negedge clk);
    rst = 1'b0;
    mAcc = 8'd0;
    for (int i = 0; i < 8; i++) mRegs[i] = 8'd0;
    expPcQ.delete();
  endtask

  // Starts a run and either waits for HALT (bounded) or stops in EXEC of the last modelled instruction.
  task automatic applyStimulus(input string tag, input int maxInstr, input bit holdStart,
                               input bit expectHalt, input logic [7:0] expAcc);
    int nInstr;
    int fetch0;
    int doneBefore;
    int cnt;
    issRun(maxInstr, nInstr);
    doneBefore = doneCount;
    @(negedge clk);
    startIn = 1'b1;
    @(negedge clk);
    startIn = holdStart;
    fetch0 = cycleCnt;
    checkOutput({tag, "_busy_rise"}, {31'd0, busyOut}, 32'd1);
    if (expectHalt) begin
      cnt = 0;
      while (cnt < 3 * nInstr + 20) begin
        @(negedge clk);
        cnt++;
        if (doneOut) begin
          startIn = 1'b0;
          break;
        end
        startIn = holdStart;
      end
      startIn = 1'b0;
      checkOutput({tag, "_done_seen"}, {31'd0, doneOut}, 32'd1);
      checkOutput({tag, "_latency"}, cycleCnt - fetch0, 3 * nInstr);
      checkOutput({tag, "_busy_drop"}, {31'd0, busyOut}, 32'd0);
      checkOutput({tag, "_acc"}, {24'd0, accOut}, {24'd0, expAcc});
      checkOutput({tag, "_queue"}, expPcQ.size(), 32'd0);
      repeat (4) @(negedge clk);
      checkOutput({tag, "_done_count"}, doneCount - doneBefore, 32'd1);
      checkOutput({tag, "_acc_hold"}, {24'd0, accOut}, {24'd0, expAcc});
      checkOutput({tag, "_idle_busy"}, {31'd0, busyOut}, 32'd0);
      checkOutput({tag, "_idle_done"}, {31'd0, doneOut}, 32'd0);
    end else begin
      repeat (3 * (nInstr - 1) + 2) begin
        @(negedge clk);
        startIn = holdStart;
      end
      startIn = 1'b0;
      checkOutput({tag, "_still_busy"}, {31'd0, busyOut}, 32'd1);
      checkOutput({tag, "_no_done"}, doneCount - doneBefore, 32'd0);
      checkOutput({tag, "_queue"}, expPcQ.size(), 32'd0);
    end
  endtask

  initial begin
    fillHalt();
    mAcc = 8'd0;
    for (int i = 0; i < 8; i++) mRegs[i] = 8'd0;
    #2;
    applyReset("reset");

    // LDI 5; HALT
    imem[0] = 8'h75; imem[1] = 8'hF8;
    applyStimulus("t1", 64, 1'b0, 1'b1, 8'd5);

    // LDI 3; ST r2; LDI 1; ADD r2; HALT
    fillHalt();
    imem[0] = 8'h73; imem[1] = 8'hF2; imem[2] = 8'h71; imem[3] = 8'h02; imem[4] = 8'hF8;
    applyStimulus("t2", 64, 1'b0, 1'b1, 8'd4);

    // Countdown loop: BNEZ taken once, falls through at acc=0.
    fillHalt();
    imem[0] = 8'h72; imem[1] = 8'hF0; imem[2] = 8'h71; imem[3] = 8'hF1;
    imem[4] = 8'h60; imem[5] = 8'h11; imem[6] = 8'hF0; imem[7] = 8'hE4; imem[8] = 8'hF8;
    applyStimulus("t3", 64, 1'b0, 1'b1, 8'd0);

    // start_in held high through a whole run.
    fillHalt();
    imem[0] = 8'h73; imem[1] = 8'hF2; imem[2] = 8'h71; imem[3] = 8'h02; imem[4] = 8'hF8;
    applyStimulus("t5", 64, 1'b1, 1'b1, 8'd4);

    // pc wrap: 16 LDIs, no HALT anywhere; run 18 instructions then reset.
    for (int i = 0; i < DEPTH; i++) imem[i] = 8'h70 | 8'(i);
    applyStimulus("t4", 18, 1'b0, 1'b0, 8'd0);
    checkOutput("t4_acc_after_wrap", {24'd0, accOut}, 32'd0);
    applyReset("t4_reset");

    // Reset during EXEC of the ADD: writeback must be dropped.
    fillHalt();
    imem[0] = 8'h73; imem[1] = 8'hF2; imem[2] = 8'h71; imem[3] = 8'h02; imem[4] = 8'hF8;
    applyStimulus("t6", 4, 1'b0, 1'b0, 8'd0);
    checkOutput("t6_acc_before_reset", {24'd0, accOut}, 32'd1);
    applyReset("t6_reset");
    repeat (2) @(negedge clk);
    checkOutput("t6_acc_after", {24'd0, accOut}, 32'd0);
    checkOutput("t6_idle", {31'd0, busyOut}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
